// File: rtl/mole_hit_judge.sv
// mole_hit_judge: round engine that times a round, places moles pseudo-randomly and judges key presses.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   state      one-hot game state (0001 before, 0010 in game, 0100 lost, 1000 win)
//   level      difficulty 0..9, larger values behave as 9
//   hitkey     debounced hole keys, active-low, bit i = hole i
//   hitSuccess verdict pulse: 10 hit, 01 lost, 00 idle
//   timeIsup   round timer expired, held while in game
//   moleOn     mole visible
//   molePos    hole index of the current mole
//   timeLeft   remaining round ticks
module mole_hit_judge #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ROUND_TICKS = 30,
    parameter int GAP_TICKS   = 2,
    parameter int BASE_SHOW   = 10,
    parameter int STEP_SHOW   = 1,
    parameter int MIN_SHOW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic [3:0]  level,
    input  logic [15:0] hitkey,
    output logic [1:0]  hitSuccess,
    output logic        timeIsup,
    output logic        moleOn,
    output logic [3:0]  molePos,
    output logic [7:0]  timeLeft
);
    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} fsm_t;
    fsm_t fsm, fsm_d;
    logic [31:0] presc;
    logic [7:0]  lfsr, cnt, cnt_d, show_len, show_len_d, show_ticks;
    logic [15:0] prev, press;
    logic [3:0]  lvl, pos_d, new_pos;
    logic [1:0]  hit_d;
    logic        in_game, tick, mole_on_d;
    int          raw;
    assign in_game = state == 4'b0010;
    assign tick    = in_game && presc == 32'(TICK_DIV - 1);
    assign press   = prev & ~hitkey;
    // Avoid showing the mole in the same hole twice in a row.
    assign new_pos = (lfsr[3:0] == molePos) ? lfsr[3:0] + 4'd1 : lfsr[3:0];
    // Clamp the level before subtracting so the window never wraps below the floor.
    assign lvl        = (level > 4'd9) ? 4'd9 : level;
    assign raw        = BASE_SHOW - STEP_SHOW * int'({28'd0, lvl});
    assign show_ticks = (raw < MIN_SHOW) ? 8'(MIN_SHOW) : 8'(raw);
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            lfsr     <= 8'h5A;
            prev     <= 16'hFFFF;
            timeLeft <= 8'(ROUND_TICKS);
            timeIsup <= 1'b0;
        end else begin
            presc    <= (!in_game || tick) ? '0 : presc + 32'd1;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            prev     <= hitkey;
            timeLeft <= !in_game ? 8'(ROUND_TICKS) : (tick && timeLeft != 8'd0) ? timeLeft - 8'd1 : timeLeft;
            timeIsup <= in_game && timeLeft == 8'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm        <= IDLE;
            cnt        <= '0;
            show_len   <= '0;
            moleOn     <= 1'b0;
            molePos    <= '0;
            hitSuccess <= 2'b00;
        end else begin
            fsm        <= fsm_d;
            cnt        <= cnt_d;
            show_len   <= show_len_d;
            moleOn     <= mole_on_d;
            molePos    <= pos_d;
            hitSuccess <= hit_d;
        end
    end
    always_comb begin
        fsm_d      = fsm;
        cnt_d      = cnt;
        show_len_d = show_len;
        mole_on_d  = moleOn;
        pos_d      = molePos;
        hit_d      = 2'b00;
        if (!in_game) begin
            fsm_d     = IDLE;
            cnt_d     = '0;
            mole_on_d = 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    fsm_d = GAP;
                    cnt_d = '0;
                end
                GAP: begin
                    if (timeLeft == 8'd0) begin
                        fsm_d     = DONE;
                        mole_on_d = 1'b0;
                    end else if (tick) begin
                        if (cnt == 8'(GAP_TICKS - 1)) begin
                            fsm_d      = SHOW;
                            cnt_d      = '0;
                            pos_d      = new_pos;
                            mole_on_d  = 1'b1;
                            show_len_d = show_ticks;
                        end else begin
                            cnt_d = cnt + 8'd1;
                        end
                    end
                end
                SHOW: begin
                    // Correct hit outranks a wrong press and expiry in the same cycle.
                    if (timeLeft == 8'd0) begin
                        fsm_d     = DONE;
                        mole_on_d = 1'b0;
                    end else if (press[molePos] || |press || (tick && cnt == show_len - 8'd1)) begin
                        hit_d     = press[molePos] ? 2'b10 : 2'b01;
                        fsm_d     = GAP;
                        cnt_d     = '0;
                        mole_on_d = 1'b0;
                    end else if (tick) begin
                        cnt_d = cnt + 8'd1;
                    end
                end
                default: mole_on_d = 1'b0;
            endcase
        end
    end
endmodule
